// File: rtl/neural_unit.sv
// Time-multiplexed integrate-and-fire unit: NEURON_CNT neurons share one weight port.
// Accumulate walks the neurons for each spike address; activation evaluates one neuron per cycle.
module neural_unit #(
    parameter int NEURON_CNT         = 4,
    parameter int PRE_SYN_LAYER_SIZE = 32,
    parameter int WGHT_WIDTH         = 8,
    parameter int POT_WIDTH          = 16,
    parameter int THRESHOLD          = 100,
    parameter int LEAK_SHIFT         = 2,
    parameter int NEURAL_LAT         = 4,
    parameter int TIME_STEPS         = 8
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            en_accum,
    input  logic                                            en_activ,
    input  logic [$clog2(PRE_SYN_LAYER_SIZE)-1:0]           spk_addr,
    output logic                                            wght_rd_en,
    output logic [$clog2(PRE_SYN_LAYER_SIZE*NEURON_CNT)-1:0] wght_addr,
    input  logic signed [WGHT_WIDTH-1:0]                    wght_data,
    output logic [NEURON_CNT-1:0]                           spk_out,
    output logic                                            spk_valid,
    output logic                                            run_done
);
    localparam int WAW = $clog2(PRE_SYN_LAYER_SIZE*NEURON_CNT);
    localparam int LW  = $clog2(NEURAL_LAT);
    localparam int NW  = (NEURON_CNT > 1) ? $clog2(NEURON_CNT) : 1;
    localparam int CW  = $clog2(NEURON_CNT + 1);
    localparam int TW  = (TIME_STEPS > 1) ? $clog2(TIME_STEPS) : 1;
    localparam logic signed [POT_WIDTH-1:0] POT_MAX = {1'b0, {(POT_WIDTH-1){1'b1}}};
    localparam logic signed [POT_WIDTH-1:0] POT_MIN = {1'b1, {(POT_WIDTH-1){1'b0}}};
    localparam logic signed [POT_WIDTH-1:0] THR     = POT_WIDTH'(THRESHOLD);

    logic [LW-1:0]               lat_cnt_q, lat_cnt_d;
    logic [NW-1:0]               nrn_idx_q, nrn_idx_d;
    logic [CW-1:0]               act_cnt_q, act_cnt_d;
    logic [TW-1:0]               tstep_q, tstep_d;
    logic signed [POT_WIDTH-1:0] pot_q [NEURON_CNT];
    logic signed [POT_WIDTH-1:0] pot_d [NEURON_CNT];
    logic [NEURON_CNT-1:0]       spk_out_q, spk_out_d;
    logic                        spk_valid_q, run_done_q;

    logic acc_act, acc_commit, eval_act, last_eval, run_end;

    function automatic logic signed [POT_WIDTH-1:0] sat_add(
        input logic signed [POT_WIDTH-1:0]  a,
        input logic signed [WGHT_WIDTH-1:0] w
    );
        logic [POT_WIDTH:0] s;
        s = {a[POT_WIDTH-1], a} + {{(POT_WIDTH+1-WGHT_WIDTH){w[WGHT_WIDTH-1]}}, w};
        // Top two bits disagree only when the sum left the representable range
        if (s[POT_WIDTH] != s[POT_WIDTH-1])
            return s[POT_WIDTH] ? POT_MIN : POT_MAX;
        return s[POT_WIDTH-1:0];
    endfunction

    assign acc_act    = en_accum && !en_activ;
    assign acc_commit = acc_act && (lat_cnt_q == LW'(1));
    assign eval_act   = en_activ && (act_cnt_q < CW'(NEURON_CNT));
    assign last_eval  = en_activ && (act_cnt_q == CW'(NEURON_CNT-1));
    assign run_end    = last_eval && (tstep_q == TW'(TIME_STEPS-1));

    // Read strobe is forced low while reset is held, even if en_accum is high.
    assign wght_rd_en = rst && acc_act && (lat_cnt_q == '0);
    assign wght_addr  = wght_rd_en ? (WAW'(spk_addr) * WAW'(NEURON_CNT) + WAW'(nrn_idx_q)) : '0;

    always_comb begin
        lat_cnt_d = '0;
        nrn_idx_d = '0;
        if (acc_act) begin
            if (lat_cnt_q == LW'(NEURAL_LAT-1)) begin
                nrn_idx_d = (nrn_idx_q == NW'(NEURON_CNT-1)) ? '0 : nrn_idx_q + NW'(1);
            end else begin
                lat_cnt_d = lat_cnt_q + LW'(1);
                nrn_idx_d = nrn_idx_q;
            end
        end

        act_cnt_d = '0;
        if (en_activ)
            act_cnt_d = eval_act ? act_cnt_q + CW'(1) : act_cnt_q;

        tstep_d = tstep_q;
        if (last_eval)
            tstep_d = run_end ? '0 : tstep_q + TW'(1);

        for (int k = 0; k < NEURON_CNT; k++) begin
            pot_d[k]     = pot_q[k];
            spk_out_d[k] = spk_out_q[k];
            if (acc_commit && nrn_idx_q == NW'(k)) begin
                pot_d[k] = sat_add(pot_q[k], wght_data);
            end else if (eval_act && act_cnt_q == CW'(k)) begin
                if (pot_q[k] >= THR) begin
                    spk_out_d[k] = 1'b1;
                    pot_d[k]     = pot_q[k] - THR;
                end else begin
                    spk_out_d[k] = 1'b0;
                    pot_d[k]     = pot_q[k] - (pot_q[k] >>> LEAK_SHIFT);
                end
            end
            if (run_end)
                pot_d[k] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_cnt_q   <= '0;
            nrn_idx_q   <= '0;
            act_cnt_q   <= '0;
            tstep_q     <= '0;
            spk_out_q   <= '0;
            spk_valid_q <= 1'b0;
            run_done_q  <= 1'b0;
            for (int k = 0; k < NEURON_CNT; k++)
                pot_q[k] <= '0;
        end else begin
            lat_cnt_q   <= lat_cnt_d;
            nrn_idx_q   <= nrn_idx_d;
            act_cnt_q   <= act_cnt_d;
            tstep_q     <= tstep_d;
            spk_out_q   <= spk_out_d;
            spk_valid_q <= last_eval;
            run_done_q  <= run_end;
            for (int k = 0; k < NEURON_CNT; k++)
                pot_q[k] <= pot_d[k];
        end
    end

    assign spk_out   = spk_out_q;
    assign spk_valid = spk_valid_q;
    assign run_done  = run_done_q;

endmodule

// File: tb/tb_neural_unit.sv
// Directed + randomized bench for neural_unit; expectations come from an arithmetic model of
// potentials, spikes and the time-step count kept here.
module tb_neural_unit;
    localparam int N   = 4;
    localparam int PRE = 32;
    localparam int WW  = 8;
    localparam int PW  = 16;
    localparam int TH  = 100;
    localparam int LS  = 2;
    localparam int LAT = 4;
    localparam int TS  = 8;
    localparam int AW  = $clog2(PRE);
    localparam int WAW = $clog2(PRE*N);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 en_accum = 1'b0;
    logic                 en_activ = 1'b0;
    logic [AW-1:0]        spk_addr = '0;
    logic                 wght_rd_en;
    logic [WAW-1:0]       wght_addr;
    logic signed [WW-1:0] wght_data;
    logic [N-1:0]         spk_out;
    logic                 spk_valid;
    logic                 run_done;

    int n_assert = 0;
    int n_fail   = 0;

    logic signed [WW-1:0] mem_w [PRE*N];
    int                   pot_m [N];
    logic [N-1:0]         spk_m = '0;
    int                   tstep_m = 0;

    neural_unit #(
        .NEURON_CNT(N), .PRE_SYN_LAYER_SIZE(PRE), .WGHT_WIDTH(WW), .POT_WIDTH(PW),
        .THRESHOLD(TH), .LEAK_SHIFT(LS), .NEURAL_LAT(LAT), .TIME_STEPS(TS)
    ) dut (
        .clk(clk), .rst(rst), .en_accum(en_accum), .en_activ(en_activ),
        .spk_addr(spk_addr), .wght_rd_en(wght_rd_en), .wght_addr(wght_addr),
        .wght_data(wght_data), .spk_out(spk_out), .spk_valid(spk_valid), .run_done(run_done)
    );

    always #5 clk = ~clk;

    // Weight memory: one-cycle read latency
    always @(posedge clk) if (wght_rd_en) wght_data <= mem_w[wght_addr];

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic check_pots(input string tag);
        for (int k = 0; k < N; k++)
            check($sformatf("%s pot%0d", tag, k), 32'($signed(dut.pot_q[k])), pot_m[k]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // len cycles of accumulate at one address, then one idle cycle
    task automatic accum(input int addr, input int len);
        int n;
        for (int c = 0; c < len; c++) begin
            n = (c / LAT) % N;
            en_accum = 1'b1;
            en_activ = 1'b0;
            spk_addr = AW'(addr);
            @(negedge clk);
            if (c % LAT == 0) begin
                check("rd_en", 32'(wght_rd_en), 1);
                check("wght_addr", 32'(wght_addr), addr * N + n);
            end else begin
                check("rd_en_idle", 32'(wght_rd_en), 0);
            end
            if (c % LAT == 1)
                pot_m[n] = sat(pot_m[n] + int'(mem_w[addr * N + n]));
            step();
        end
        en_accum = 1'b0;
        @(negedge clk);
        check("rd_en_off", 32'(wght_rd_en), 0);
        step();
        $display("accum addr=%0d len=%0d pots=%0d %0d %0d %0d", addr, len,
                 pot_m[0], pot_m[1], pot_m[2], pot_m[3]);
    endtask

    // N evaluation cycles plus 'extra' surplus en_activ cycles, then idle
    task automatic activate(input bit acc_too, input int extra);
        bit exp_done;
        exp_done = 1'b0;
        for (int c = 0; c <= N + extra; c++) begin
            en_activ = (c < N + extra);
            en_accum = acc_too && (c < N + extra);
            @(negedge clk);
            check("rd_en_activ", 32'(wght_rd_en), 0);
            if (c == N) begin
                tstep_m++;
                exp_done = (tstep_m == TS);
                if (exp_done) begin
                    for (int k = 0; k < N; k++) pot_m[k] = 0;
                    tstep_m = 0;
                end
                check("spk_valid", 32'(spk_valid), 1);
                check("run_done", 32'(run_done), 32'(exp_done));
                check("spk_out", 32'(spk_out), 32'(spk_m));
                check_pots("activ");
            end else begin
                check("spk_valid_low", 32'(spk_valid), 0);
                check("run_done_low", 32'(run_done), 0);
            end
            if (c < N) begin
                if (pot_m[c] >= TH) begin
                    spk_m[c] = 1'b1;
                    pot_m[c] = pot_m[c] - TH;
                end else begin
                    spk_m[c] = 1'b0;
                    pot_m[c] = pot_m[c] - (pot_m[c] >>> LS);
                end
            end
            step();
        end
        en_activ = 1'b0;
        en_accum = 1'b0;
        @(negedge clk);
        check("spk_valid_pulse_end", 32'(spk_valid), 0);
        check("spk_out_hold", 32'(spk_out), 32'(spk_m));
        step();
        $display("activate extra=%0d spk=%b run_done_exp=%0d tstep=%0d", extra, spk_m, exp_done, tstep_m);
    endtask

    initial begin
        int t, d, addr, len;
        for (int i = 0; i < PRE * N; i++) mem_w[i] = '0;
        for (int k = 0; k < N; k++) pot_m[k] = 0;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("rst spk_out", 32'(spk_out), 0);
        check("rst spk_valid", 32'(spk_valid), 0);
        check("rst run_done", 32'(run_done), 0);
        check("rst wght_addr", 32'(wght_addr), 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        $display("reset released");

        // Reset asserted mid-accumulate while a read strobe is active
        for (int k = 0; k < N; k++) mem_w[3 * N + k] = WW'(10 + k);
        for (int c = 0; c < 2 * LAT; c++) begin
            en_accum = 1'b1;
            spk_addr = AW'(3);
            step();
        end
        @(negedge clk);
        check("pre_rst rd_en", 32'(wght_rd_en), 1);
        check("pre_rst addr", 32'(wght_addr), 3 * N + 2);
        check("pre_rst pot0", 32'($signed(dut.pot_q[0])), 10);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst rd_en", 32'(wght_rd_en), 0);
        check("midrst wght_addr", 32'(wght_addr), 0);
        check("midrst spk_out", 32'(spk_out), 0);
        check("midrst spk_valid", 32'(spk_valid), 0);
        check("midrst run_done", 32'(run_done), 0);
        check_pots("midrst");
        @(negedge clk);
        rst = 1'b1;
        en_accum = 1'b0;
        step();
        $display("mid-accumulate reset done");

        // Single address, weight 30 everywhere
        for (int k = 0; k < N; k++) mem_w[5 * N + k] = WW'(30);
        accum(5, LAT * N);
        check_pots("single_addr");
        for (int i = 0; i < 3; i++) accum(5, LAT * N);
        check_pots("pots120");
        activate(1'b0, 0);
        check("fire spk_out", 32'(spk_out), 32'(4'b1111));

        // Leak: bring pots to +40 / -40
        for (int k = 0; k < N; k++) mem_w[6 * N + k] = (k % 2 == 0) ? WW'(20) : WW'(-60);
        accum(6, LAT * N);
        check_pots("pre_leak");
        activate(1'b0, 0);
        check("leak spk_out", 32'(spk_out), 0);

        // Saturation: walk pots to +/-32760 then push past the rails
        forever begin
            bit done;
            done = 1'b1;
            for (int k = 0; k < N; k++) begin
                t = (k % 2 == 0) ? 32760 : -32760;
                d = t - pot_m[k];
                if (d > 127) d = 127;
                if (d < -128) d = -128;
                if (d != 0) done = 1'b0;
                mem_w[7 * N + k] = WW'(d);
            end
            if (done) break;
            accum(7, LAT * N);
        end
        check_pots("pre_sat");
        for (int k = 0; k < N; k++) mem_w[7 * N + k] = (k % 2 == 0) ? WW'(100) : WW'(-100);
        accum(7, LAT * N);
        check("sat_hi", 32'($signed(dut.pot_q[0])), 32767);
        check("sat_lo", 32'($signed(dut.pot_q[1])), -32768);
        check_pots("sat");
        activate(1'b0, 0);

        // Randomized time steps up to the end of the run, with one abandoned partial window
        for (int s = 0; s < TS - 3; s++) begin
            int nw;
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) begin
                addr = $urandom_range(0, PRE - 1);
                for (int k = 0; k < N; k++) mem_w[addr * N + k] = WW'($urandom_range(0, 255));
                len = (s == 1 && w == 0) ? $urandom_range(2, LAT * N - 1) : LAT * N;
                accum(addr, len);
                check_pots("rand_accum");
            end
            activate(1'(($urandom_range(0, 1))), $urandom_range(0, 2));
        end
        check("run_end tstep", 32'(dut.tstep_q), 0);
        check_pots("run_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/neural_unit.md
NEURAL_UNIT -- requirements
Module: neural_unit

Interface
REQ-001 SHALL have parameter NEURON_CNT, default 4: neurons served by this unit.
REQ-002 SHALL have parameter PRE_SYN_LAYER_SIZE, default 32: pre-synaptic neurons (spike address range).
REQ-003 SHALL have parameter WGHT_WIDTH, default 8: signed weight width.
REQ-004 SHALL have parameter POT_WIDTH, default 16: signed membrane potential width.
REQ-005 SHALL have parameter THRESHOLD, default 100: firing threshold (positive).
REQ-006 SHALL have parameter LEAK_SHIFT, default 2: leak = pot >>> LEAK_SHIFT (arithmetic).
REQ-007 SHALL have parameter NEURAL_LAT, default 4: cycles per neuron per spike address (>= 2).
REQ-008 SHALL have parameter TIME_STEPS, default 8: activations per inference.
REQ-009 SHALL have port clk  input  1  sole clock, rising edge.
REQ-010 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-011 SHALL have port en_accum  input  1  accumulate phase enable from event control.
REQ-012 SHALL have port en_activ  input  1  activation phase enable from event control.
REQ-013 SHALL have port spk_addr  input  $clog2(PRE_SYN_LAYER_SIZE)  current pre-synaptic spike address.
REQ-014 SHALL have port wght_rd_en  output  1  weight memory read strobe.
REQ-015 SHALL have port wght_addr  output  $clog2(PRE_SYN_LAYER_SIZE*NEURON_CNT)  weight address.
REQ-016 SHALL have port wght_data  input  WGHT_WIDTH  signed weight, valid one cycle after wght_rd_en.
REQ-017 SHALL have port spk_out  output  NEURON_CNT  registered spike vector, bit k = neuron k.
REQ-018 SHALL have port spk_valid  output  1  one-cycle pulse: spk_out complete for this time step.
REQ-019 SHALL have port run_done  output  1  one-cycle pulse: final time step finished.

Function
REQ-020 SHALL hold NEURON_CNT signed POT_WIDTH potentials in registers.
REQ-021 Accumulate: while en_accum=1 and en_activ=0, lat_cnt SHALL count 0..NEURAL_LAT-1 and nrn_idx 0..NEURON_CNT-1 (nrn_idx advances on lat_cnt wrap, both wrap to 0); both SHALL clear in any cycle en_accum=0.
REQ-022 At lat_cnt=0: wght_rd_en=1, wght_addr=spk_addr*NEURON_CNT+nrn_idx (combinational); else wght_rd_en=0.
REQ-023 At lat_cnt=1: pot[nrn_idx] SHALL update to sat(pot + sign-extended wght_data); lat_cnt 2..NEURAL_LAT-1 idle.
REQ-024 sat() SHALL clamp to [-2^(POT_WIDTH-1), 2^(POT_WIDTH-1)-1].
REQ-025 spk_addr SHALL be sampled at lat_cnt=0 only; it is held stable for NEURAL_LAT*NEURON_CNT cycles per address.
REQ-026 Activation: act_cnt SHALL count cycles with en_activ=1 from 0; cycle k<NEURON_CNT evaluates neuron k; act_cnt clears when en_activ=0.
REQ-027 Evaluation: pot>=THRESHOLD -> spk_out[k]<=1, pot<=pot-THRESHOLD; else spk_out[k]<=0, pot<=pot-(pot>>>LEAK_SHIFT).
REQ-028 spk_valid SHALL pulse one cycle, the cycle after neuron NEURON_CNT-1 is evaluated; cycles with act_cnt>=NEURON_CNT SHALL have no effect.
REQ-029 en_activ=1 SHALL take priority over en_accum; no weight read or accumulate while en_activ=1.
REQ-030 tstep counter SHALL increment per spk_valid; on the TIME_STEPS-th, run_done SHALL pulse coincident with spk_valid, all pots SHALL clear to 0 same edge, tstep wraps to 0.
REQ-031 spk_out SHALL hold its value until next evaluation of each bit.
REQ-032 en_accum dropping mid-window SHALL abandon the partial neuron; accumulates already committed stand.

Reset
REQ-033 rst=0 SHALL asynchronously clear all pots, counters, spk_out, spk_valid, run_done, wght_rd_en; wght_addr SHALL then be 0.
REQ-034 Reset deassertion mid-phase SHALL restart with all counters at 0 at the next enable.

Verification
REQ-035 Reset: assert rst=0 mid-accumulate -> all outputs 0, pots 0 immediately, no wght_rd_en.
REQ-036 Single address: spk_addr=5, en_accum 16 cycles, wght_data=30 -> wght_addr 20,21,22,23 at cycles 0,4,8,12; all pots=30.
REQ-037 Fire: pots 120, en_activ 4 cycles -> spk_out=4'b1111, pots=20, spk_valid pulse cycle 4.
REQ-038 Leak: pots 40 and -40, activate -> spk_out=0, pots 30 and -30.
REQ-039 Saturation: pot 32760 plus weight 100 -> 32767; pot -32760 plus -100 -> -32768.
REQ-040 Run end: 8 full time steps -> run_done with 8th spk_valid, pots 0, tstep back to 0.
